// File: rtl/tt_probe_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tt_probe_capture
//  Purpose  : Masked-match triggered logic capture of a WIDTH-bit probe bus
//             into a DEPTH-entry circular buffer with a PRE-sample
//             pre-trigger window. Once the capture is complete, the buffer
//             is read back in logical order (index 0 = oldest sample,
//             index PRE = trigger sample).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : clock
//    rst_n      : asynchronous active-low reset
//    ena        : sample enable; when low, nothing is written, counted or
//                 evaluated. arm and abort are still honoured.
//    probe      : bus being captured
//    trig_mask  : bits that take part in the trigger compare
//    trig_value : trigger pattern
//    arm        : single-cycle start/restart of a capture
//    abort      : return to IDLE; has priority over arm
//    rd_en      : read request; only honoured in DONE
//    rd_addr    : logical read index (0 = oldest sample)
//    rd_data    : registered read data; holds its value between reads
//    rd_valid   : rd_data was updated this cycle
//    state      : 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//    done       : high while state is DONE
// ============================================================================
module tt_probe_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PRE   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         probe,
  input  logic [WIDTH-1:0]         trig_mask,
  input  logic [WIDTH-1:0]         trig_value,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int ADDR_W = $clog2(DEPTH);
  // Counters must be able to hold the value DEPTH itself.
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Samples from the trigger onwards, the trigger sample included.
  localparam int POST   = DEPTH - PRE;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PRE_C   = CNT_W'(PRE);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Storage and control registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem_q [DEPTH];

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0]  fill_cnt_q,  fill_cnt_d;
  logic [CNT_W-1:0]  post_cnt_q,  post_cnt_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [WIDTH-1:0]  rd_data_q,   rd_data_d;
  logic              rd_valid_q,  rd_valid_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_match;
  logic              w_eligible;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_ptr_inc;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [CNT_W-1:0]  w_fill_next;
  logic [CNT_W-1:0]  w_post_inc;

  // Only bits selected by the mask take part; a zero mask always matches.
  assign w_match = (((probe ^ trig_value) & trig_mask) == '0);

  // A match only counts once the pre-trigger window has been filled. With
  // PRE=0 every sample is eligible, so the compare is dropped altogether.
  generate
    if (PRE == 0) begin : g_pre_none
      assign w_eligible = 1'b1;
    end else begin : g_pre_window
      assign w_eligible = (fill_cnt_q >= PRE_C);
    end
  endgenerate

  // DEPTH is a power of two, so the natural ADDR_W-bit wrap is the modulo.
  assign w_wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
  assign w_rd_idx     = start_ptr_q + rd_addr;
  assign w_fill_next  = (fill_cnt_q == DEPTH_C) ? fill_cnt_q : (fill_cnt_q + ONE_C);
  assign w_post_inc   = post_cnt_q + ONE_C;

  // arm and abort both pre-empt a write on their edge.
  assign w_wr_en = ena && !abort && !arm &&
                   ((state_q == S_ARMED) || (state_q == S_TRIG));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    start_ptr_d = start_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    // Readback is decided on the state before this edge, independently of
    // any arm/abort arriving on the same edge.
    if ((state_q == S_DONE) && rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[w_rd_idx];
    end

    if (abort) begin
      // The buffer is kept, but leaving DONE makes it unreadable.
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      post_cnt_d = '0;
    end else if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      post_cnt_d = '0;
    end else if (ena) begin
      unique case (state_q)
        S_ARMED: begin
          wr_ptr_d   = w_wr_ptr_inc;
          fill_cnt_d = w_fill_next;
          if (w_match && w_eligible) begin
            post_cnt_d = ONE_C;
            if (POST == 1) begin
              state_d     = S_DONE;
              // After the final write the write pointer sits on the oldest
              // entry of the full circular buffer.
              start_ptr_d = w_wr_ptr_inc;
            end else begin
              state_d = S_TRIG;
            end
          end
        end
        S_TRIG: begin
          wr_ptr_d   = w_wr_ptr_inc;
          fill_cnt_d = w_fill_next;
          post_cnt_d = w_post_inc;
          if (w_post_inc == POST_C) begin
            state_d     = S_DONE;
            start_ptr_d = w_wr_ptr_inc;
          end
        end
        default: begin
          // IDLE and DONE hold everything.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      start_ptr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      start_ptr_q <= start_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Sample storage is deliberately left without reset so it can map onto
  // plain storage cells; its contents only matter once a capture completes.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= probe;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/tt_probe_capture.md
Name: tt_probe_capture

Overview:
Parametrised capture engine for Tiny Tapeout user projects. It records a WIDTH-bit probe bus, such as uo_out or uio_out of a user design, into a DEPTH-entry circular buffer. Capture uses a masked-match trigger with a configurable pre-trigger window. After capture, the buffer is read back in order, oldest sample first, so the bench or on-chip readout sees the same pin activity in silicon and in simulation.

Parameters:
WIDTH, 8, probe/sample width in bits (1..32)
DEPTH, 16, buffer entries; power of two, >=2; ADDR_W = clog2(DEPTH) derived locally
PRE, 4, samples kept before the trigger (0..DEPTH-1); POST = DEPTH-PRE, counting the trigger sample itself

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  sample enable; low = no write, no counting, no trigger evaluation
probe  in  WIDTH  bus being captured
trig_mask  in  WIDTH  bits compared for trigger
trig_value  in  WIDTH  trigger pattern
arm  in  1  single-cycle start/restart
abort  in  1  return to IDLE; has priority over arm
rd_en  in  1  read request
rd_addr  in  ADDR_W  logical index; 0 = oldest sample, PRE = trigger sample
rd_data  out  WIDTH  registered read data
rd_valid  out  1  rd_data updated this cycle
state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
done  out  1  high while state==DONE

Behaviour:
- Reset: state=IDLE, wr_ptr=0, fill_cnt=0, post_cnt=0, start_ptr=0, rd_data=0, rd_valid=0, done=0. Buffer contents are not reset; they are undefined until the first DONE.
- Reset mid-capture or mid-read: all outputs return to reset values immediately (asynchronous).
- abort=1 at an edge in any state: go to IDLE and clear the counters. Buffer is retained but unreadable.
- arm=1 (abort=0) at an edge in any state: go to ARMED with wr_ptr=0, fill_cnt=0, post_cnt=0. No write occurs on the arm edge.
- ARMED, ena=1:
  - Write probe to mem[wr_ptr]; wr_ptr increments mod DEPTH; fill_cnt saturates at DEPTH.
  - Trigger = ((probe ^ trig_value) & trig_mask)==0 AND fill_cnt (value before this write) >= PRE.
  - On trigger, the trigger sample is written and post_cnt=1. If POST==1, go directly to DONE; otherwise go to TRIGGERED.
  - A match while fill_cnt<PRE is ignored.
- TRIGGERED, ena=1: write probe and increment post_cnt. When post_cnt reaches POST after the write, go to DONE.
- On entry to DONE: start_ptr = wr_ptr after the final write, i.e. the oldest entry. No further writes occur.
- DONE: each rd_en=1 edge gives, on the next cycle, rd_data = mem[(start_ptr+rd_addr) mod DEPTH] and rd_valid=1.
- rd_en outside DONE, or rd_en=0: rd_valid=0 next cycle and rd_data holds its value.
- Back-to-back reads are allowed, one per cycle at 1-cycle latency.
- ena=0: state, pointers and counters all hold; arm and abort are still honoured.
- Write pointer wrap in ARMED is normal; only the last PRE pre-trigger samples survive.
- Trigger mask of 0: triggers on the first eligible sample.

Test Plan:
- Setup for all scenarios: WIDTH=8, DEPTH=16, PRE=4. probe = free counter; the first armed sample is 0x01. Mask 0xFF, value 0x20.
- Basic capture: run the setup → DONE after sample 0x2B; rd_addr 0..15 return 0x1C..0x2B with rd_valid one cycle after rd_en; rd_addr 4 returns 0x20.
- Early match ignored: first sample 0x0E, mask 0x0F, value 0x00 → 0x10 (fill_cnt=2) is ignored; trigger at 0x20; readback 0x1C..0x2B.
- ena gaps: drop ena for 3 cycles during TRIGGERED while the counter advances → those 3 values are absent and readback stays contiguous around the gap; DONE occurs 3 cycles later.
- abort/arm priority: abort and arm together in TRIGGERED → IDLE, done=0. rd_en then gives rd_valid=0. A later arm restarts cleanly.
- Async reset: assert rst_n low between edges during a DONE read burst → rd_valid, rd_data, done and state read 0 before the next edge.
- PRE=0 build: trigger on the first sample matching 0x05 → rd_addr 0 returns 0x05, rd_addr 15 returns 0x14.
